hilo_div: RTL and testbench
===========================

# hilo_div

Multi-cycle integer divider that produces the HI/LO write for the CPU's HI/LO register file. Executes MIPS `div`/`divu` as a one-bit-per-cycle restoring divider. On completion it drives remainder on `hi_o`, quotient on `lo_o` and a one-cycle `we_o` that goes straight to the HI/LO write port. While busy it holds `busy_o` so the pipeline stalls.

## Interface
- `WIDTH`, 32: operand and result width in bits.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `start_i`  in  1  request a divide; sampled only in IDLE.
- `signed_i`  in  1  1 = `div` (two's complement), 0 = `divu`; sampled with `start_i`.
- `opdata1_i`  in  WIDTH  dividend; sampled with `start_i`.
- `opdata2_i`  in  WIDTH  divisor; sampled with `start_i`.
- `annul_i`  in  1  cancel any in-flight divide (pipeline flush/exception).
- `busy_o`  out  1  1 whenever state != IDLE; stall request.
- `we_o`  out  1  HI/LO write enable; single-cycle pulse.
- `hi_o`  out  WIDTH  remainder; valid while `we_o`=1, holds last result afterwards.
- `lo_o`  out  WIDTH  quotient; valid while `we_o`=1, holds last result afterwards.

## Operation
- States: IDLE, BYZERO, ON, END.
- Reset (`rst`=0, asynchronous):
  - state=IDLE; `hi_o`=`lo_o`=0; `we_o`=0; `busy_o`=0.
  - Iteration counter and internal operand registers cleared.
- IDLE, `start_i`=1 and `annul_i`=0:
  - Latch operands and sign mode.
  - Divisor==0 → BYZERO; otherwise → ON with counter=0.
  - `start_i` in any other state is ignored.
- Signed mode: divide absolute values as unsigned.
  - Quotient is negated iff operand signs differ.
  - Remainder takes the dividend's sign.
  - |−2^(WIDTH−1)| is treated as unsigned 2^(WIDTH−1).
- ON, one iteration per cycle:
  - Shift {rem, quo} left by 1; trial = rem − divisor, computed WIDTH+1 bits wide.
  - trial ≥ 0 → rem = trial and quo LSB = 1; otherwise keep rem and set quo LSB = 0.
  - After WIDTH iterations, apply sign fixup, load `hi_o`/`lo_o`, go to END.
- BYZERO:
  - Load `lo_o` = all ones, `hi_o` = dividend (unmodified); go to END.
- END: `we_o`=1 for exactly this cycle; next state IDLE.
- `annul_i`=1 in BYZERO, ON or END:
  - Next state is IDLE; `hi_o`/`lo_o` are not updated.
  - `we_o` is forced 0 in the same cycle (`we_o` = END && !`annul_i`).
- `annul_i`=1 together with `start_i` in IDLE: request is dropped.

## Timing
- Accept edge = E0.
- Normal divide:
  - ON iterations occur on E1..E(WIDTH); END is entered at E(WIDTH).
  - `we_o` is high in the cycle after E(WIDTH), i.e. WIDTH+1 cycles after E0 (33 for WIDTH=32).
- Divide by zero: END is entered at E1; `we_o` is high in the cycle after E1.
- `busy_o` rises the cycle after E0 and falls the cycle after END.
- A new `start_i` can be accepted on the first IDLE cycle; no dead cycle beyond END.
- Back-to-back throughput: WIDTH+2 cycles per divide.
- An asynchronous reset mid-operation takes effect immediately; no `we_o` is issued for the aborted divide.

## Configuration
- `HILO_DIV_SIGNED_EN` defined:
  - `signed_i` is honoured; abs/negate logic is present.
- `HILO_DIV_SIGNED_EN` undefined:
  - `signed_i` is ignored and every operation is `divu`; no sign logic is synthesised.
  - Latency and all other behaviour are unchanged.

## Test plan
- `divu` 100/7 (0x64/0x7): `we_o` pulses 33 cycles after accept; `lo_o`=0x0000000E, `hi_o`=0x00000002.
- `div` −7/2 (0xFFFFFFF9/0x2): `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF. Without `HILO_DIV_SIGNED_EN`: `lo_o`=0x7FFFFFFC, `hi_o`=0x00000001.
- `div` 0x80000000/0xFFFFFFFF: `lo_o`=0x80000000, `hi_o`=0x00000000.
- 0x1234/0 in either mode: `we_o` 2 cycles after accept; `lo_o`=0xFFFFFFFF, `hi_o`=0x00001234.
- `annul_i`=1 at iteration 10:
  - `busy_o`=0 next cycle; `we_o` never pulses; `hi_o`/`lo_o` keep their prior values.
  - An immediate new start, 9/3, gives `lo_o`=3, `hi_o`=0.
- `rst`=0 asserted asynchronously at iteration 20:
  - `hi_o`=`lo_o`=0 and `busy_o`=`we_o`=0 before the next edge.
  - No `we_o` pulse after release.

Source files
------------

// File: rtl/hilo_div.sv
// rtl/hilo_div.sv - one-bit-per-cycle restoring divider driving the HI/LO write port
// Optional signed (div) support is compiled in with HILO_DIV_SIGNED_EN.
module hilo_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH-1:0] w_fix_quo;
  logic [WIDTH-1:0] w_fix_rem;

  assign w_accept   = (r_state == S_IDLE) && start_i && !annul_i;
  assign w_div_zero = (opdata2_i == '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // Remainder is always below the divisor, so the low WIDTH bits of the difference are exact.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_divisor});
  assign w_rem_sub  = w_shift[WIDTH-1:0] - r_divisor;
  assign w_rem_next = w_ge ? w_rem_sub : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

`ifdef HILO_DIV_SIGNED_EN
  logic r_neg_quo;
  logic r_neg_rem;
  logic w_sgn1;
  logic w_sgn2;

  assign w_sgn1    = signed_i & opdata1_i[WIDTH-1];
  assign w_sgn2    = signed_i & opdata2_i[WIDTH-1];
  assign w_abs1    = w_sgn1 ? -opdata1_i : opdata1_i;
  assign w_abs2    = w_sgn2 ? -opdata2_i : opdata2_i;
  assign w_fix_quo = r_neg_quo ? -w_quo_next : w_quo_next;
  assign w_fix_rem = r_neg_rem ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_accept) begin
      r_neg_quo <= w_sgn1 ^ w_sgn2;
      r_neg_rem <= w_sgn1;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_i;
  assign w_abs1          = opdata1_i;
  assign w_abs2          = opdata2_i;
  assign w_fix_quo       = w_quo_next;
  assign w_fix_rem       = w_rem_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_div_zero ? S_BYZERO : S_ON;
      S_BYZERO: w_next = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)     w_next = S_IDLE;
        else if (w_last) w_next = S_END;
      end
      S_END:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // For a zero divisor r_quo carries the raw dividend through to HI.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_divisor <= w_abs2;
            r_quo     <= w_div_zero ? opdata1_i : w_abs1;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_hi <= w_fix_rem;
              r_lo <= w_fix_quo;
            end
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            r_hi <= r_quo;
            r_lo <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (r_state != S_IDLE);
  assign we_o   = (r_state == S_END) && !annul_i;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_hilo_div.sv
// tb/tb_hilo_div.sv - directed and random checks of hilo_div against an arithmetic model
module tb_hilo_div;

`ifdef HILO_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        annul_i = 1'b0;
  logic        busy_o;
  logic        we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  hilo_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .busy_o(busy_o), .we_o(we_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, ua, ub, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = (sa < 0) ? -sa : sa;
      ub = (sb < 0) ? -sb : sb;
      lq = ua / ub;
      lr = ua % ub;
      if ((sa < 0) != (sb < 0)) lq = -lq;
      if (sa < 0) lr = -lr;
      q = 32'(lq);
      r = 32'(lr);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eq, er;
    int lat;
    int exp_lat;
    model(sgn, a, b, eq, er);
    exp_lat = (b == 32'd0) ? 2 : 33;
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    @(posedge clk);
    #1 start_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, "_busy"}, 32'(busy_o), 32'd1);
      if (we_o) lat = k;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_lo"}, lo_o, eq);
    check({tag, "_hi"}, hi_o, er);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy_o, we_o}, 32'd0);
    last_hi = er;
    last_lo = eq;
  endtask

  initial begin
    int pulses;
    logic [31:0] a, b;
    #1;
    check("reset_outs", {30'd0, busy_o, we_o}, 32'd0);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    check("divu_100_7_const_lo", lo_o, 32'h0000_000E);
    check("divu_100_7_const_hi", hi_o, 32'h0000_0002);
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_div(1'b1, 32'h1234, 32'h0, "div_by_zero_s");
    run_div(1'b0, 32'h1234, 32'h0, "div_by_zero_u");
    run_div(1'b1, 32'h8000_0000, 32'h8000_0000, "div_min_min");
    run_div(1'b0, 32'hFFFF_FFFF, 32'h1, "divu_max_1");

    // annul mid-divide, then start again straight away
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h13;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1 check("annul_we_forced", 32'(we_o), 32'd0);
    @(posedge clk);
    #1 annul_i = 1'b0;
    @(negedge clk);
    check("annul_busy", 32'(busy_o), 32'd0);
    check("annul_hi_held", hi_o, last_hi);
    check("annul_lo_held", lo_o, last_lo);
    run_div(1'b0, 32'd9, 32'd3, "after_annul");

    // start together with annul in IDLE is dropped
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(posedge clk);
    #1 start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);
    check("start_annul_dropped", 32'(busy_o), 32'd0);

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2:       b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(1'($urandom_range(0, 1)), a, b, $sformatf("rand%0d", i));
    end

    // asynchronous reset mid-divide
    start_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'h7654_3210; opdata2_i = 32'h0000_0123;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_rst_outs", {30'd0, busy_o, we_o}, 32'd0);
    check("async_rst_hi", hi_o, 32'd0);
    check("async_rst_lo", lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (we_o) pulses++;
    end
    check("async_rst_no_we", 32'(pulses), 32'd0);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
